lsu_writeback: RTL and testbench
================================

Name: lsu_writeback

Overview:
- Writeback stage directly downstream of the load/store unit in the rv32e pipeline.
- Merges two result streams into the single register-file write port:
  - ALU results, available the cycle they are produced.
  - Load data, returned by the LSU one cycle after the load is issued.
- Tracks the destination register of an outstanding load.
- Buffers at most one colliding ALU result.
- Raises a load-use hazard flag for the controller.

Parameters:
- ADDR_W, 4, register index width (16 registers, rv32e).
- TIMEOUT, 8, maximum cycles WAIT may last before abort; range 2..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- alu_wb_flag_i  input  1  ALU result valid this cycle.
- alu_rd_i  input  ADDR_W  ALU destination register.
- alu_wdata_i  input  32  ALU result.
- load_issue_i  input  1  load dispatched to LSU this cycle; same cycle as the LSU's load_flag.
- load_rd_i  input  ADDR_W  load destination register.
- lsu_wb_flag_i  input  1  LSU load data valid; one-cycle pulse.
- lsu_wdata_i  input  32  extended load data from LSU.
- rs1_i  input  ADDR_W  source 1 of the instruction in decode.
- rs2_i  input  ADDR_W  source 2 of the instruction in decode.
- rf_we_o  output  1  register-file write enable (registered).
- rf_waddr_o  output  ADDR_W  write address (registered).
- rf_wdata_o  output  32  write data (registered).
- hazard_o  output  1  decode must stall (combinational).
- error_o  output  1  sticky protocol error.
- wb_count_o  output  32  committed-write counter.

Behaviour:
- Reset (asynchronous, rst_n low): every register clears immediately.
  - state = IDLE.
  - skid_valid = 0; pending_rd = 0; timer = 0.
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
  - error_o = 0; wb_count_o = 0.
  - An in-flight load or skid entry is discarded.
- States:
  - IDLE: no load outstanding.
  - WAIT: load outstanding, pending_rd valid.
- Write selection, each cycle; priority is top-down:
  - WAIT and lsu_wb_flag_i: write (pending_rd, lsu_wdata_i); go to IDLE.
  - IDLE and skid_valid: write the skid entry.
  - IDLE and alu_wb_flag_i with skid empty: write the ALU result directly.
  - Selected write appears on rf_* exactly one cycle later (latency 1).
  - If nothing is selected, rf_we_o = 0 and rf_waddr_o/rf_wdata_o hold their previous values.
- Skid buffer (one entry):
  - alu_wb_flag_i not written directly that cycle → ALU result enters the skid. This covers:
    - arrival in WAIT;
    - arrival in IDLE while the skid drains (entry replaced in FIFO order).
  - alu_wb_flag_i while the skid is full and not draining → new result dropped, error_o set.
- Register x0:
  - Any write selected with address 0 is suppressed: rf_we_o = 0, counter unchanged.
  - load_issue_i with load_rd_i = 0 still enters WAIT, and hazard compares ignore index 0.
- IDLE → WAIT on load_issue_i: capture pending_rd = load_rd_i; timer = 0.
  - lsu_wb_flag_i in IDLE → ignored, error_o set.
  - load_issue_i in WAIT → ignored, error_o set.
  - Same-cycle load_issue_i and ALU write in IDLE → both accepted.
- WAIT timeout: timer increments each cycle. timer == TIMEOUT-1 without lsu_wb_flag_i → IDLE, error_o set, no write.
- hazard_o = 1 when a source is nonzero and matches a pending destination:
  - (state==WAIT and (rs1_i==pending_rd or rs2_i==pending_rd)), or
  - (skid_valid and either source equals the skid rd).
- error_o: sticky until reset.
- wb_count_o: increments by 1 each cycle rf_we_o is asserted; wraps 0xFFFFFFFF → 0.

Test Plan:
- ALU direct path:
  - Stimulus: reset; alu_wb_flag_i=1, alu_rd_i=5, alu_wdata_i=0x1234 for one cycle.
  - Response: next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; wb_count_o=1; hazard_o=0 throughout.
- Load path:
  - Stimulus: load_issue_i, load_rd_i=3; next cycle rs1_i=3; next cycle lsu_wb_flag_i, data 0xFFFFFF80.
  - Response: hazard_o=1 during WAIT; rf write (3, 0xFFFFFF80) the cycle after the flag; hazard_o=0 after.
- Collision:
  - Stimulus: load to rd 4 pending; ALU (rd 6, 0xAA) arrives in WAIT; LSU returns 0x55 next cycle.
  - Response: writes (4, 0x55) then (6, 0xAA) on consecutive cycles; error_o stays 0.
- x0 and protocol errors:
  - ALU write to rd 0 → rf_we_o stays 0, count unchanged.
  - lsu_wb_flag_i in IDLE → error_o=1, and it stays 1.
- Timeout:
  - Stimulus: load issued, no LSU response.
  - Response: after 8 cycles state returns to IDLE, error_o=1, no rf write.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst_n=0 between clock edges while in WAIT with the skid full.
  - Response: outputs zero immediately, without a clock edge; after release, no stale write ever appears.

Source files
------------

// File: rtl/lsu_writeback.sv
// Writeback stage behind the load/store unit of the rv32e pipeline.
// It merges ALU results and LSU load data onto one register-file write port.
// It tracks the destination of a single outstanding load and holds at most one
// ALU result that collides with load data. It also raises a load-use hazard
// flag for decode and latches any protocol violation in a sticky error flag.
module lsu_writeback #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_wb_flag_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [31:0]       alu_wdata_i,
    input  logic              load_issue_i,
    input  logic [ADDR_W-1:0] load_rd_i,
    input  logic              lsu_wb_flag_i,
    input  logic [31:0]       lsu_wdata_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [31:0]       rf_wdata_o,
    output logic              hazard_o,
    output logic              error_o,
    output logic [31:0]       wb_count_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The last WAIT cycle the LSU is allowed before the load is abandoned.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] pendingRd_q;
    logic [7:0]        timer_q;
    logic              skidValid_q;
    logic [ADDR_W-1:0] skidRd_q;
    logic [31:0]       skidData_q;
    logic              rfWe_q;
    logic [ADDR_W-1:0] rfWaddr_q;
    logic [31:0]       rfWdata_q;
    logic              error_q;
    logic [31:0]       wbCount_q;

    logic              lsuHit;
    logic              skidDrain;
    logic              aluDirect;
    logic              selValid;
    logic [ADDR_W-1:0] selRd;
    logic [31:0]       selData;
    logic              selCommit;
    logic              pendHit;
    logic              skidHit;

    // Pick this cycle's write: load data first, then the skid entry, then a fresh ALU result.
    always_comb begin
        lsuHit    = (state_q == ST_WAIT) && lsu_wb_flag_i;
        skidDrain = (state_q == ST_IDLE) && skidValid_q;
        aluDirect = (state_q == ST_IDLE) && !skidValid_q && alu_wb_flag_i;
        selValid  = 1'b0;
        selRd     = '0;
        selData   = '0;
        if (lsuHit) begin
            selValid = 1'b1;
            selRd    = pendingRd_q;
            selData  = lsu_wdata_i;
        end else if (skidDrain) begin
            selValid = 1'b1;
            selRd    = skidRd_q;
            selData  = skidData_q;
        end else if (aluDirect) begin
            selValid = 1'b1;
            selRd    = alu_rd_i;
            selData  = alu_wdata_i;
        end
        // x0 is hardwired to zero, so a write to it is simply dropped.
        selCommit = selValid && (selRd != '0);
    end

    // Decode must stall while a nonzero source waits on the pending load or the skid entry.
    always_comb begin
        pendHit = (state_q == ST_WAIT) &&
                  (((rs1_i != '0) && (rs1_i == pendingRd_q)) ||
                   ((rs2_i != '0) && (rs2_i == pendingRd_q)));
        skidHit = skidValid_q &&
                  (((rs1_i != '0) && (rs1_i == skidRd_q)) ||
                   ((rs2_i != '0) && (rs2_i == skidRd_q)));
        hazard_o = pendHit || skidHit;
    end

    // State machine, skid buffer, registered write port, counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pendingRd_q <= '0;
            timer_q     <= '0;
            skidValid_q <= 1'b0;
            skidRd_q    <= '0;
            skidData_q  <= '0;
            rfWe_q      <= 1'b0;
            rfWaddr_q   <= '0;
            rfWdata_q   <= '0;
            error_q     <= 1'b0;
            wbCount_q   <= '0;
        end else begin
            rfWe_q <= selCommit;
            if (selCommit) begin
                rfWaddr_q <= selRd;
                rfWdata_q <= selData;
                wbCount_q <= wbCount_q + 32'd1;
            end

            // An ALU result that cannot go straight to the port lands in the skid.
            // A draining entry frees its slot this cycle. A full, idle-blocked slot drops the newcomer.
            if (alu_wb_flag_i && !aluDirect) begin
                if (!skidValid_q || skidDrain) begin
                    skidValid_q <= 1'b1;
                    skidRd_q    <= alu_rd_i;
                    skidData_q  <= alu_wdata_i;
                end else begin
                    error_q <= 1'b1;
                end
            end else if (skidDrain) begin
                skidValid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (lsu_wb_flag_i) begin
                        error_q <= 1'b1;
                    end
                    if (load_issue_i) begin
                        state_q     <= ST_WAIT;
                        pendingRd_q <= load_rd_i;
                        timer_q     <= '0;
                    end
                end
                ST_WAIT: begin
                    if (load_issue_i) begin
                        error_q <= 1'b1;
                    end
                    if (lsu_wb_flag_i) begin
                        state_q <= ST_IDLE;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q <= ST_IDLE;
                        error_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rf_we_o    = rfWe_q;
    assign rf_waddr_o = rfWaddr_q;
    assign rf_wdata_o = rfWdata_q;
    assign error_o    = error_q;
    assign wb_count_o = wbCount_q;

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback.
// A table of per-cycle vectors drives the main paths. Hand-written sequences
// cover timeout, skid overflow and asynchronous reset. Expected register-file
// writes are queued when stimulus is applied and compared one cycle later.
module tb_lsu_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_wb_flag_i;
    logic [3:0]  alu_rd_i;
    logic [31:0] alu_wdata_i;
    logic        load_issue_i;
    logic [3:0]  load_rd_i;
    logic        lsu_wb_flag_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  rs1_i;
    logic [3:0]  rs2_i;
    logic        rf_we_o;
    logic [3:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        hazard_o;
    logic        error_o;
    logic [31:0] wb_count_o;

    typedef struct {
        logic        aluV;
        logic [3:0]  aluRd;
        logic [31:0] aluData;
        logic        ld;
        logic [3:0]  ldRd;
        logic        lsuV;
        logic [31:0] lsuData;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        expHaz;
        logic        expWe;
        logic [3:0]  expAddr;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
    } wrExp_t;

    vec_t   vecs[$];
    wrExp_t sbQ[$];
    int     checks;
    int     errors;
    int     expCount;

    lsu_writeback #(.ADDR_W(4), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_wb_flag_i(alu_wb_flag_i),
        .alu_rd_i     (alu_rd_i),
        .alu_wdata_i  (alu_wdata_i),
        .load_issue_i (load_issue_i),
        .load_rd_i    (load_rd_i),
        .lsu_wb_flag_i(lsu_wb_flag_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .hazard_o     (hazard_o),
        .error_o      (error_o),
        .wb_count_o   (wb_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input int aluV, input int aluRd, input logic [31:0] aluData,
                          input int ld, input int ldRd, input int lsuV, input logic [31:0] lsuData,
                          input int rs1, input int rs2, input int expHaz,
                          input int expWe, input int expAddr, input logic [31:0] expData,
                          input int expErr);
        vec_t v;
        v.aluV    = 1'(aluV);
        v.aluRd   = 4'(aluRd);
        v.aluData = aluData;
        v.ld      = 1'(ld);
        v.ldRd    = 4'(ldRd);
        v.lsuV    = 1'(lsuV);
        v.lsuData = lsuData;
        v.rs1     = 4'(rs1);
        v.rs2     = 4'(rs2);
        v.expHaz  = 1'(expHaz);
        v.expWe   = 1'(expWe);
        v.expAddr = 4'(expAddr);
        v.expData = expData;
        v.expErr  = 1'(expErr);
        vecs.push_back(v);
    endtask

    task automatic idleInputs();
        alu_wb_flag_i = 1'b0;
        alu_rd_i      = '0;
        alu_wdata_i   = '0;
        load_issue_i  = 1'b0;
        load_rd_i     = '0;
        lsu_wb_flag_i = 1'b0;
        lsu_wdata_i   = '0;
        rs1_i         = '0;
        rs2_i         = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        alu_wb_flag_i = v.aluV;
        alu_rd_i      = v.aluRd;
        alu_wdata_i   = v.aluData;
        load_issue_i  = v.ld;
        load_rd_i     = v.ldRd;
        lsu_wb_flag_i = v.lsuV;
        lsu_wdata_i   = v.lsuData;
        rs1_i         = v.rs1;
        rs2_i         = v.rs2;
    endtask

    task automatic expectWrite(input logic we, input logic [3:0] addr, input logic [31:0] data);
        wrExp_t e;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        sbQ.push_back(e);
    endtask

    task automatic popAndCheck(input string tag);
        wrExp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.queue: got empty expected an entry", tag);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, ".we"}, 32'(rf_we_o), 32'(e.we));
            if (e.we) begin
                checkOutput({tag, ".addr"}, 32'(rf_waddr_o), 32'(e.addr));
                checkOutput({tag, ".data"}, rf_wdata_o, e.data);
                expCount++;
            end
            checkOutput({tag, ".count"}, wb_count_o, 32'(expCount));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        expCount = 0;
        sbQ.delete();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expCount = 0;
        rst_n    = 1'b0;
        idleInputs();

        //       alu rd data        ld rd lsu data         rs1 rs2 haz we ad data         err
        addVec(1,  5, 32'h1234,     0, 0, 0, 32'h0,        0,  0,  0,  1, 5, 32'h1234,     0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        1, 3, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        3,  0,  1,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        0, 0, 1, 32'hFFFFFF80, 3,  0,  1,  1, 3, 32'hFFFFFF80, 0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        3,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        1, 4, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(1,  6, 32'hAA,       0, 0, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        0, 0, 1, 32'h55,       6,  0,  1,  1, 4, 32'h55,       0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        6,  0,  1,  1, 6, 32'hAA,       0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        6,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        1, 7, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(1,  8, 32'h11,       0, 0, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        0, 0, 1, 32'h77,       0,  0,  0,  1, 7, 32'h77,       0);
        addVec(1,  9, 32'h22,       0, 0, 0, 32'h0,        0,  8,  1,  1, 8, 32'h11,       0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        0,  9,  1,  1, 9, 32'h22,       0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        0,  9,  0,  0, 0, 32'h0,        0);
        addVec(1,  0, 32'h999,      0, 0, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        1, 0, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        0, 0, 1, 32'h5,        0,  0,  0,  0, 0, 32'h0,        0);
        addVec(1, 11, 32'h33,       1, 10, 0, 32'h0,       0,  0,  0,  1, 11, 32'h33,      0);
        addVec(0,  0, 32'h0,        0, 0, 1, 32'h44,       10, 0,  1,  1, 10, 32'h44,      0);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        10, 0,  0,  0, 0, 32'h0,        0);
        addVec(0,  0, 32'h0,        0, 0, 1, 32'h1,        0,  0,  0,  0, 0, 32'h0,        1);
        addVec(0,  0, 32'h0,        0, 0, 0, 32'h0,        0,  0,  0,  0, 0, 32'h0,        1);
        addVec(1, 12, 32'hBEEF,     0, 0, 0, 32'h0,        0,  0,  0,  1, 12, 32'hBEEF,    1);

        // Reset state.
        tick();
        checkOutput("reset.we",    32'(rf_we_o),    32'h0);
        checkOutput("reset.addr",  32'(rf_waddr_o), 32'h0);
        checkOutput("reset.data",  rf_wdata_o,      32'h0);
        checkOutput("reset.err",   32'(error_o),    32'h0);
        checkOutput("reset.count", wb_count_o,      32'h0);
        checkOutput("reset.haz",   32'(hazard_o),   32'h0);
        #2;
        rst_n = 1'b1;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
            #1;
            checkOutput({tag, ".haz"}, 32'(hazard_o), 32'(vecs[i].expHaz));
            expectWrite(vecs[i].expWe, vecs[i].expAddr, vecs[i].expData);
            tick();
            popAndCheck(tag);
            checkOutput({tag, ".err"}, 32'(error_o), 32'(vecs[i].expErr));
        end
        idleInputs();

        // Timeout: a load with no response is abandoned after eight WAIT cycles.
        doReset();
        load_issue_i = 1'b1;
        load_rd_i    = 4'd2;
        expectWrite(1'b0, 4'd0, 32'h0);
        tick();
        popAndCheck("tmo.issue");
        load_issue_i = 1'b0;
        rs1_i        = 4'd2;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checkOutput($sformatf("tmo%0d.haz", k), 32'(hazard_o), 32'h1);
            expectWrite(1'b0, 4'd0, 32'h0);
            tick();
            popAndCheck($sformatf("tmo%0d", k));
            checkOutput($sformatf("tmo%0d.err", k), 32'(error_o), (k == 8) ? 32'h1 : 32'h0);
        end
        #1;
        checkOutput("tmo.hazIdle", 32'(hazard_o), 32'h0);
        idleInputs();

        // Skid overflow: a second ALU result in WAIT is dropped and flagged.
        doReset();
        load_issue_i = 1'b1;
        load_rd_i    = 4'd1;
        expectWrite(1'b0, 4'd0, 32'h0);
        tick();
        popAndCheck("ovf.issue");
        load_issue_i  = 1'b0;
        alu_wb_flag_i = 1'b1;
        alu_rd_i      = 4'd2;
        alu_wdata_i   = 32'h20;
        expectWrite(1'b0, 4'd0, 32'h0);
        tick();
        popAndCheck("ovf.skid");
        checkOutput("ovf.errBefore", 32'(error_o), 32'h0);
        alu_rd_i    = 4'd3;
        alu_wdata_i = 32'h30;
        expectWrite(1'b0, 4'd0, 32'h0);
        tick();
        popAndCheck("ovf.drop");
        checkOutput("ovf.errAfter", 32'(error_o), 32'h1);
        alu_wb_flag_i = 1'b0;
        lsu_wb_flag_i = 1'b1;
        lsu_wdata_i   = 32'h10;
        expectWrite(1'b1, 4'd1, 32'h10);
        tick();
        popAndCheck("ovf.load");
        lsu_wb_flag_i = 1'b0;
        expectWrite(1'b1, 4'd2, 32'h20);
        tick();
        popAndCheck("ovf.drain");
        expectWrite(1'b0, 4'd0, 32'h0);
        tick();
        popAndCheck("ovf.quiet");
        idleInputs();

        // Asynchronous reset while a load is pending and the skid is full.
        doReset();
        alu_wb_flag_i = 1'b1;
        alu_rd_i      = 4'd9;
        alu_wdata_i   = 32'hDEAD;
        load_issue_i  = 1'b1;
        load_rd_i     = 4'd5;
        expectWrite(1'b1, 4'd9, 32'hDEAD);
        tick();
        popAndCheck("ar.first");
        load_issue_i = 1'b0;
        alu_rd_i     = 4'd6;
        alu_wdata_i  = 32'h66;
        expectWrite(1'b0, 4'd0, 32'h0);
        tick();
        popAndCheck("ar.skid");
        alu_wb_flag_i = 1'b0;
        rs1_i         = 4'd6;
        rs2_i         = 4'd5;
        #1;
        checkOutput("ar.hazBefore", 32'(hazard_o), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("ar.we",    32'(rf_we_o),    32'h0);
        checkOutput("ar.addr",  32'(rf_waddr_o), 32'h0);
        checkOutput("ar.data",  rf_wdata_o,      32'h0);
        checkOutput("ar.count", wb_count_o,      32'h0);
        checkOutput("ar.err",   32'(error_o),    32'h0);
        checkOutput("ar.haz",   32'(hazard_o),   32'h0);
        #1;
        rst_n    = 1'b1;
        expCount = 0;
        sbQ.delete();
        for (int k = 0; k < 6; k++) begin
            expectWrite(1'b0, 4'd0, 32'h0);
            tick();
            popAndCheck($sformatf("ar.post%0d", k));
            checkOutput($sformatf("ar.post%0d.haz", k), 32'(hazard_o), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
